// File: rtl/mrd_col_seq.sv
// Column sequencer: runs the MRD datapath once per column and streams each captured inverse column out.
// Latency: LOAD(1) + ITER(STEP_LAT*ITER_NUM) + OUT(>=1) cycles per column; col_data is held while col_ready=0.
// Optional: define MRD_ABORT_EN to add an abort input that returns the FSM to IDLE from any busy state.
module mrd_col_seq #(
  parameter int DIMENSION = 16,
  parameter int WIDTH     = 8,
  parameter int ITER_NUM  = 2,
  parameter int STEP_LAT  = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic signed [WIDTH-1:0]        init_diag,
`ifdef MRD_ABORT_EN
  input  logic                           abort,
`endif
  output logic                           busy,
  output logic                           done,
  output logic                           mrd_clr,
  output logic                           mrd_en,
  output logic [DIMENSION*WIDTH-1:0]     ej,
  output logic [DIMENSION*WIDTH-1:0]     minit,
  input  logic [DIMENSION*WIDTH-1:0]     m_iter,
  output logic [$clog2(DIMENSION)-1:0]   col_idx,
  output logic [DIMENSION*WIDTH-1:0]     col_data,
  output logic                           col_valid,
  input  logic                           col_ready
);

  localparam int IDX_W    = $clog2(DIMENSION);
  localparam int ITER_CYC = STEP_LAT * ITER_NUM;
  localparam int CNT_W    = $clog2(ITER_CYC + 1);
  localparam int VW       = DIMENSION * WIDTH;

  typedef enum logic [1:0] {IDLE, LOAD, ITER, OUT} state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   j_q, j_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [VW-1:0]      ej_q, ej_d;
  logic [VW-1:0]      minit_q, minit_d;
  logic [VW-1:0]      col_data_q, col_data_d;
  logic               done_q, done_d;

  logic iter_last, col_last, xfer, abort_hit, load_vec;

  assign iter_last = (cnt_q == CNT_W'(ITER_CYC - 1));
  assign col_last  = (j_q == IDX_W'(DIMENSION - 1));
  assign xfer      = (state_q == OUT) && col_ready;
`ifdef MRD_ABORT_EN
  assign abort_hit = abort && (state_q != IDLE);
`else
  assign abort_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = LOAD;
      LOAD:    state_d = ITER;
      ITER:    if (iter_last) state_d = OUT;
      OUT:     if (xfer) state_d = col_last ? IDLE : LOAD;
      default: state_d = IDLE;
    endcase
    if (abort_hit) state_d = IDLE;
  end

  always_comb begin
    busy      = (state_q != IDLE);
    mrd_clr   = (state_q == LOAD);
    mrd_en    = (state_q == ITER);
    col_valid = (state_q == OUT);
    ej        = ej_q;
    minit     = minit_q;
    col_idx   = j_q;
    col_data  = col_data_q;
    done      = done_q;
  end

  // Column vectors are built on the edge entering LOAD so they are already valid while mrd_clr is high.
  always_comb begin
    j_d        = j_q;
    cnt_d      = cnt_q;
    ej_d       = ej_q;
    minit_d    = minit_q;
    col_data_d = col_data_q;
    done_d     = 1'b0;
    load_vec   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          j_d      = '0;
          load_vec = 1'b1;
        end
      end
      LOAD: cnt_d = '0;
      ITER: begin
        cnt_d = cnt_q + 1'b1;
        if (iter_last) col_data_d = m_iter;
      end
      OUT: begin
        if (col_ready) begin
          if (col_last) begin
            j_d     = '0;
            done_d  = 1'b1;
            ej_d    = '0;
            minit_d = '0;
          end else begin
            j_d      = j_q + 1'b1;
            load_vec = 1'b1;
          end
        end
      end
      default: ;
    endcase
    if (load_vec) begin
      ej_d    = '0;
      minit_d = '0;
      ej_d[int'(j_d)*WIDTH +: WIDTH]    = WIDTH'(1);
      minit_d[int'(j_d)*WIDTH +: WIDTH] = init_diag;
    end
    if (abort_hit) begin
      j_d     = '0;
      cnt_d   = '0;
      done_d  = 1'b0;
      ej_d    = '0;
      minit_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      j_q        <= '0;
      cnt_q      <= '0;
      ej_q       <= '0;
      minit_q    <= '0;
      col_data_q <= '0;
      done_q     <= 1'b0;
    end else begin
      j_q        <= j_d;
      cnt_q      <= cnt_d;
      ej_q       <= ej_d;
      minit_q    <= minit_d;
      col_data_q <= col_data_d;
      done_q     <= done_d;
    end
  end

endmodule

// File: tb/tb_mrd_col_seq.sv
// Directed bench for mrd_col_seq: scoreboard of expected columns, checked on every transfer.
module tb_mrd_col_seq;

  localparam int D  = 16;
  localparam int W  = 8;
  localparam int VW = D * W;

  logic                  clk = 1'b0;
  logic                  rst = 1'b0;
  logic                  start = 1'b0;
  logic                  col_ready = 1'b0;
  logic signed [W-1:0]   init_diag = 8'sd3;
  logic                  busy, done, mrd_clr, mrd_en, col_valid;
  logic [VW-1:0]         ej, minit, m_iter, col_data;
  logic [3:0]            col_idx;
  logic                  ab;
`ifdef MRD_ABORT_EN
  logic                  abort = 1'b0;
  assign ab = abort;
`else
  assign ab = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign m_iter = {D{8'(int'(col_idx) + 1)}};

  mrd_col_seq dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .init_diag (init_diag),
`ifdef MRD_ABORT_EN
    .abort     (abort),
`endif
    .busy      (busy),
    .done      (done),
    .mrd_clr   (mrd_clr),
    .mrd_en    (mrd_en),
    .ej        (ej),
    .minit     (minit),
    .m_iter    (m_iter),
    .col_idx   (col_idx),
    .col_data  (col_data),
    .col_valid (col_valid),
    .col_ready (col_ready)
  );

  task automatic chk(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"},     VW'(busy),      '0);
    chk({tag, "_done"},     VW'(done),      '0);
    chk({tag, "_clr"},      VW'(mrd_clr),   '0);
    chk({tag, "_en"},       VW'(mrd_en),    '0);
    chk({tag, "_valid"},    VW'(col_valid), '0);
    chk({tag, "_idx"},      VW'(col_idx),   '0);
    chk({tag, "_ej"},       ej,             '0);
    chk({tag, "_minit"},    minit,          '0);
    chk({tag, "_col_data"}, col_data,       '0);
  endtask

  // Scoreboard and run statistics
  logic [VW-1:0] exp_q[$];
  int            exp_idx_q[$];
  int            cyc = 0;
  int            xfers, dones, en_cycles, first_valid_cyc, done_cyc;
  logic [VW-1:0] ej5, minit5;
  bit            seen5;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst) begin
      if (col_valid && col_ready && !ab) begin
        xfers++;
        checks++;
        assert (exp_q.size() > 0) else begin
          errors++;
          $error("FAIL sb_underflow observed=transfer idx %0d expected=no transfer", col_idx);
        end
        if (exp_q.size() > 0) begin
          chk("xfer_col_data", col_data, exp_q.pop_front());
          chk("xfer_col_idx", VW'(col_idx), VW'(exp_idx_q.pop_front()));
        end
      end
      if (done) begin
        dones++;
        done_cyc = cyc;
      end
      if (mrd_en) en_cycles++;
      if (col_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (mrd_clr && col_idx == 4'd5 && !seen5) begin
        seen5  = 1'b1;
        ej5    = ej;
        minit5 = minit;
      end
    end
  end

  task automatic new_run();
    xfers = 0; dones = 0; en_cycles = 0;
    first_valid_cyc = -1; done_cyc = -1; seen5 = 1'b0;
    exp_q.delete(); exp_idx_q.delete();
    for (int k = 0; k < D; k++) begin
      exp_q.push_back({D{8'(k + 1)}});
      exp_idx_q.push_back(k);
    end
  endtask

  task automatic pulse_start(output int t0);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    t0 = cyc;
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 400 && done_cyc < 0; i++) @(negedge clk);
    chk({tag, "_done_seen"}, VW'(done_cyc >= 0), VW'(1));
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int t0;
    bit bad;
    logic [VW-1:0] e;
    int xb;

    // Reset and idle
    repeat (3) @(posedge clk);
    #1 chk_zero("reset");
    rst = 1'b1;
    bad = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (busy || col_valid || done || ej != '0) bad = 1'b1;
    end
    chk("idle_quiet", VW'(bad), '0);

    // Full run with col_ready held high
    new_run();
    col_ready = 1'b1;
    pulse_start(t0);
    wait_done("run1");
    chk("run1_first_valid_lat", VW'(first_valid_cyc - t0), VW'(9));
    chk("run1_done_lat",        VW'(done_cyc - t0),        VW'(160));
    chk("run1_xfers",           VW'(xfers),                VW'(16));
    chk("run1_dones",           VW'(dones),                VW'(1));
    chk("run1_sb_left",         VW'(exp_q.size()),         '0);
    chk("run1_en_cycles",       VW'(en_cycles),            VW'(128));
    chk("run1_busy_after",      VW'(busy),                 '0);
    chk("run1_idx_after",       VW'(col_idx),              '0);
    e = '0; e[5*W +: W] = 8'd1;
    chk("run1_ej5", ej5, e);
    e = '0; e[5*W +: W] = 8'd3;
    chk("run1_minit5", minit5, e);

    // Backpressure in column 2, ignored start in column 4
    new_run();
    pulse_start(t0);
    for (int i = 0; i < 100 && !(mrd_clr && col_idx == 4'd2); i++) @(negedge clk);
    chk("bp_reach_col2", VW'(mrd_clr && col_idx == 4'd2), VW'(1));
    @(posedge clk); #1 col_ready = 1'b0;
    for (int i = 0; i < 40 && !col_valid; i++) @(negedge clk);
    e = {D{8'd3}};
    for (int i = 0; i < 7; i++) begin
      chk("bp_valid_held", VW'(col_valid), VW'(1));
      chk("bp_idx_held",   VW'(col_idx),   VW'(2));
      chk("bp_data_held",  col_data,       e);
      chk("bp_no_load",    VW'(mrd_clr),   '0);
      @(posedge clk);
    end
    #1 col_ready = 1'b1;
    for (int i = 0; i < 100 && !(mrd_clr && col_idx == 4'd4); i++) @(negedge clk);
    chk("sb_reach_col4", VW'(mrd_clr && col_idx == 4'd4), VW'(1));
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_done("run2");
    chk("run2_xfers",     VW'(xfers),        VW'(16));
    chk("run2_dones",     VW'(dones),        VW'(1));
    chk("run2_sb_left",   VW'(exp_q.size()), '0);
    repeat (5) @(negedge clk);
    chk("run2_no_restart", VW'(busy), '0);

    // Asynchronous reset during ITER of column 7
    new_run();
    pulse_start(t0);
    for (int i = 0; i < 200 && !(mrd_en && col_idx == 4'd7); i++) @(negedge clk);
    chk("rst_reach_col7", VW'(mrd_en && col_idx == 4'd7), VW'(1));
    #2 rst = 1'b0;
    #1 chk_zero("midrst");
    @(posedge clk); #1 rst = 1'b1;

    // Restart after reset
    new_run();
    pulse_start(t0);
    for (int i = 0; i < 20 && !mrd_clr; i++) @(negedge clk);
    chk("restart_clr",  VW'(mrd_clr), VW'(1));
    chk("restart_idx0", VW'(col_idx), '0);
    e = '0; e[W-1:0] = 8'd1;
    chk("restart_ej0", ej, e);
    wait_done("run4");
    chk("run4_xfers", VW'(xfers), VW'(16));
    chk("run4_dones", VW'(dones), VW'(1));

`ifdef MRD_ABORT_EN
    // Abort colliding with a transfer in column 10
    new_run();
    pulse_start(t0);
    for (int i = 0; i < 200 && !(mrd_clr && col_idx == 4'd10); i++) @(negedge clk);
    @(posedge clk); #1 col_ready = 1'b0;
    for (int i = 0; i < 40 && !col_valid; i++) @(negedge clk);
    chk("abort_at_col10", VW'(col_idx), VW'(10));
    xb = xfers;
    @(posedge clk); #1 abort = 1'b1; col_ready = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    chk("abort_busy",  VW'(busy),      '0);
    chk("abort_valid", VW'(col_valid), '0);
    chk("abort_en",    VW'(mrd_en),    '0);
    chk("abort_idx",   VW'(col_idx),   '0);
    repeat (4) @(negedge clk);
    chk("abort_xfers", VW'(xfers), VW'(xb));
    chk("abort_dones", VW'(dones), '0);
    exp_q.delete(); exp_idx_q.delete();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
